// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, counter-based
// debounce, registered press/release edge pulses and a per-channel auto-repeat
// generator that fires while a button is held.
module button_conditioner #(
    parameter int              N_CH          = 3,
    parameter int              DB_CYCLES     = 4,
    parameter int              REPEAT_DELAY  = 16,
    parameter int              REPEAT_PERIOD = 8,
    parameter logic [N_CH-1:0] REPEAT_MASK   = {N_CH{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel,
    output logic [N_CH-1:0] rpt,
    output logic            any_press
);

    // Debounce counter only has to reach DB_CYCLES-1.
    localparam int CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    // Repeat timer saturates at the larger of the two intervals.
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST  = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TMAX_VAL = TW'(TMAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [N_CH-1:0] rise_vec;
    logic            any_press_q, any_press_d;

    // Synchroniser and combined-press next values.
    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        any_press_d = |rise_vec;
    end

    // Synchroniser chain and the any_press register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            any_press_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : ch_g
            localparam logic RPT_EN = REPEAT_MASK[gi];

            logic            level_q, level_d;
            logic [CW-1:0]   cnt_q, cnt_d;
            logic            press_q, press_d;
            logic            rel_q, rel_d;
            rpt_state_e      state_q, state_d;
            logic [TW-1:0]   timer_q, timer_d;
            logic            rpt_q, rpt_d;

            // Debounce: count consecutive disagreements, flip level on the last one.
            always_comb begin
                level_d = level_q;
                cnt_d   = cnt_q;
                press_d = 1'b0;
                rel_d   = 1'b0;
                if (sync2_q[gi] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    level_d = ~level_q;
                    press_d = ~level_q;
                    rel_d   = level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Repeat FSM: delay after press, then periodic pulses; release wins.
            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                rpt_d   = 1'b0;
                if (timer_q != TMAX_VAL) begin
                    timer_d = timer_q + 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (press_d && RPT_EN) begin
                            state_d = ST_DELAY;
                            timer_d = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (timer_q == RD_LAST) begin
                            state_d = ST_REPEAT;
                            timer_d = '0;
                            rpt_d   = 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (timer_q == RP_LAST) begin
                            timer_d = '0;
                            rpt_d   = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                endcase
                if (rel_d) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    rpt_d   = 1'b0;
                end
            end

            // Per-channel state registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    rpt_q   <= 1'b0;
                end else begin
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
                    state_q <= state_d;
                    timer_q <= timer_d;
                    rpt_q   <= rpt_d;
                end
            end

            assign level[gi]    = level_q;
            assign press[gi]    = press_q;
            assign rel[gi]      = rel_q;
            assign rpt[gi]      = rpt_q;
            assign rise_vec[gi] = press_d;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: the driver feeds directed and
// random button patterns into a timestamp-based reference model that queues the
// expected outputs; a monitor pops and compares them every cycle.
module tb_button_conditioner;

    localparam int              DB   = 4;
    localparam int              RD   = 16;
    localparam int              RP   = 8;
    localparam logic [2:0]      MASK = 3'b011;
    localparam int              MAXE = 4096;

    logic       clk;
    logic       rst;
    logic [2:0] btn_in;
    logic [2:0] level, press, rel, rpt;
    logic       any_press;

    button_conditioner #(
        .N_CH         (3),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .level    (level),
        .press    (press),
        .rel      (rel),
        .rpt      (rpt),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] rpt;
        logic       anyp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: sampled input history plus timestamps.
    logic [2:0] bh [0:MAXE-1];
    logic [2:0] mask_v;
    logic [2:0] lvl_m;
    int         edge_no  = 0;
    int         last_rst = -100;
    int         run_start[3];
    int         press_cyc[3];

    // Expected outputs for the cycle following the clock edge that samples (b, r).
    task automatic model_edge(input logic [2:0] b, input logic r);
        exp_t       x;
        logic [2:0] sv;
        int         e;
        e = edge_no;
        x = '0;
        bh[e] = b;
        if (r) begin
            last_rst = e;
            lvl_m    = 3'b000;
            for (int c = 0; c < 3; c++) begin
                run_start[c] = -1;
                press_cyc[c] = -1;
            end
        end else begin
            // Synchronised value is the input sampled two edges earlier,
            // unless a reset happened in between.
            sv = (e >= 2 && last_rst < e - 2) ? bh[e-2] : 3'b000;
            for (int c = 0; c < 3; c++) begin
                if (sv[c] == lvl_m[c]) begin
                    run_start[c] = -1;
                end else begin
                    if (run_start[c] < 0) run_start[c] = e;
                    if (e - run_start[c] + 1 == DB) begin
                        lvl_m[c]     = ~lvl_m[c];
                        run_start[c] = -1;
                        if (lvl_m[c]) begin
                            x.press[c]   = 1'b1;
                            press_cyc[c] = e;
                        end else begin
                            x.rel[c] = 1'b1;
                        end
                    end
                end
                if (mask_v[c] && lvl_m[c] && (e - press_cyc[c] >= RD) &&
                    ((e - press_cyc[c] - RD) % RP == 0))
                    x.rpt[c] = 1'b1;
            end
        end
        x.level = lvl_m;
        x.anyp  = |x.press;
        exp_q.push_back(x);
        edge_no = e + 1;
    endtask

    // Apply one cycle of stimulus and queue its expected response.
    task automatic step(input logic [2:0] b, input logic r);
        @(negedge clk);
        btn_in = b;
        rst    = r;
        model_edge(b, r);
    endtask

    task automatic hold(input logic [2:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b0);
    endtask

    task automatic chk(input string nm, input int cyc, input logic [2:0] act, input logic [2:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, want);
    endtask

    // Monitor: one expected entry per cycle, compared just after the edge.
    initial begin : monitor
        exp_t x;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("level", cyc, level, x.level);
                chk("press", cyc, press, x.press);
                chk("rel",   cyc, rel,   x.rel);
                chk("rpt",   cyc, rpt,   x.rpt);
                chk("any_press", cyc, {2'b00, any_press}, {2'b00, x.anyp});
                if (x.press != 0 || x.rel != 0 || x.rpt != 0)
                    $display("cycle %0d: level=%b press=%b rel=%b rpt=%b any_press=%b",
                             cyc, level, press, rel, rpt, any_press);
                cyc++;
            end
        end
    end

    // Stimulus: directed scenarios then randomized holds, glitches and resets.
    initial begin : driver
        logic [2:0] cur;
        int         len;
        mask_v = MASK;
        lvl_m  = 3'b000;
        for (int c = 0; c < 3; c++) begin
            run_start[c] = -1;
            press_cyc[c] = -1;
        end
        btn_in = 3'b000;
        rst    = 1'b1;

        // Reset state.
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        hold(3'b000, 5);

        // Clean press on channel 1, held and released.
        hold(3'b010, 25);
        hold(3'b000, 10);

        // Short glitch on channel 0 is filtered out.
        hold(3'b001, 3);
        hold(3'b000, 10);

        // Long hold on channel 0: repeat schedule.
        hold(3'b001, 45);
        hold(3'b000, 10);

        // Release landing exactly where a repeat would be due.
        hold(3'b001, 24);
        hold(3'b000, 20);

        // Reset pulse mid-hold, button kept pressed through it.
        hold(3'b010, 25);
        step(3'b010, 1'b1);
        hold(3'b010, 40);
        hold(3'b000, 10);

        // Simultaneous press on channels 0 and 2 (channel 2 has no repeat).
        hold(3'b101, 40);
        hold(3'b000, 10);

        // Randomized traffic.
        cur = 3'b000;
        while (edge_no < 2500) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
            cur = cur ^ 3'($urandom_range(1, 7));
            for (int k = 0; k < len; k++)
                step(cur, ($urandom_range(0, 199) == 0));
        end
        hold(3'b000, 10);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d entries left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
